// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EXE/memory-response signal bundle for pipe_hazard_ctrl.
// The controller connects through the slave modport. The pipeline side
// connects through the master modport.
// Optional macro PIPE_HAZARD_CTRL_PERF_EN adds the perf_stall_cnt_o
// stall-cycle counter output to the bundle.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 2
);
  logic             dec_valid_i;
  logic             dec_rs1_v_i;
  logic [4:0]       dec_rs1_adr_i;
  logic             dec_rs2_v_i;
  logic [4:0]       dec_rs2_adr_i;
  logic             dec_is_load_i;
  logic [4:0]       dec_rd_adr_i;
  logic             mem_rsp_v_i;
  logic             exe_branch_taken_i;
  logic             exe_exception_i;
  logic             trap_done_i;
  logic             stall_o;
  logic             issue_o;
  logic             flush_v_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] pending_cnt_o;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0]      perf_stall_cnt_o;
`endif

  modport master (
    output dec_valid_i, dec_rs1_v_i, dec_rs1_adr_i, dec_rs2_v_i, dec_rs2_adr_i,
           dec_is_load_i, dec_rd_adr_i, mem_rsp_v_i, exe_branch_taken_i,
           exe_exception_i, trap_done_i,
    input  stall_o, issue_o, flush_v_o, state_o, pending_cnt_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , input perf_stall_cnt_o
`endif
  );

  modport slave (
    input  dec_valid_i, dec_rs1_v_i, dec_rs1_adr_i, dec_rs2_v_i, dec_rs2_adr_i,
           dec_is_load_i, dec_rd_adr_i, mem_rsp_v_i, exe_branch_taken_i,
           exe_exception_i, trap_done_i,
    output stall_o, issue_o, flush_v_o, state_o, pending_cnt_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , output perf_stall_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage sequencing controller.
// An in-order scoreboard FIFO holds the destinations of outstanding loads.
// A load-use hazard or a full load queue stalls ifetch/decode.
// A taken branch or an exception in EXE starts a fixed-length flush. An
// exception is then followed by a wait for the trap unit's redirect.
// Optional macro PIPE_HAZARD_CTRL_PERF_EN adds a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MAX_LOADS    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = $clog2(MAX_LOADS + 1)
) (
  input logic               clk,
  input logic               reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  localparam int PTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_LOADS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_LOADS);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(1);

  logic [1:0]           state;
  logic [FC_W-1:0]      flush_cnt;
  logic                 trap_flag;

  logic [4:0]           rd_mem [MAX_LOADS];
  logic [MAX_LOADS-1:0] slot_v;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  logic                 run;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 redirect;
  logic                 use_hazard;
  logic                 full_hazard;
  logic                 hazard;
  logic                 issue;
  logic                 stall;

  // Queue status and the redirect request as seen from the RUN state
  always_comb begin
    run      = (state == ST_RUN);
    full     = (count == FULL_CNT);
    pop      = bus.mem_rsp_v_i & (count != '0);
    redirect = run & (bus.exe_branch_taken_i | bus.exe_exception_i);
  end

  // Hazard detection: compare sources against live entries; the entry retiring this cycle is forwarded by the RF
  always_comb begin
    use_hazard = 1'b0;
    for (int i = 0; i < MAX_LOADS; i++) begin
      if (slot_v[i] && !(pop && (rd_ptr == PTR_W'(i)))) begin
        if (bus.dec_rs1_v_i && (bus.dec_rs1_adr_i != 5'd0) &&
            (bus.dec_rs1_adr_i == rd_mem[i])) begin
          use_hazard = 1'b1;
        end
        if (bus.dec_rs2_v_i && (bus.dec_rs2_adr_i != 5'd0) &&
            (bus.dec_rs2_adr_i == rd_mem[i])) begin
          use_hazard = 1'b1;
        end
      end
    end
    full_hazard = bus.dec_is_load_i & full & ~bus.mem_rsp_v_i;
    hazard      = use_hazard | full_hazard;
  end

  // Issue/stall decisions; forced low while reset is held so outputs clear asynchronously
  always_comb begin
    issue = reset_n & bus.dec_valid_i & run & ~hazard &
            ~bus.exe_branch_taken_i & ~bus.exe_exception_i;
    stall = reset_n & bus.dec_valid_i & run & hazard;
    push  = issue & bus.dec_is_load_i & (bus.dec_rd_adr_i != 5'd0);
  end

  // Scoreboard control: pointers, per-slot valid bits and occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      slot_v <= '0;
    end else begin
      if (pop) begin
        slot_v[rd_ptr] <= 1'b0;
        rd_ptr         <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push) begin
        slot_v[wr_ptr] <= 1'b1;
        wr_ptr         <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Scoreboard data: destination registers, only read while the slot is valid
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr] <= bus.dec_rd_adr_i;
    end
  end

  // Redirect sequencer: RUN -> FLUSH for a fixed count -> RUN, or TRAP until the trap unit is done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      trap_flag <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
            trap_flag <= bus.exe_exception_i;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            state <= trap_flag ? ST_TRAP : ST_RUN;
          end
        end
        ST_TRAP: begin
          if (bus.trap_done_i) begin
            state     <= ST_RUN;
            trap_flag <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= '0;
          trap_flag <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; flush_v comes straight from the state register
  always_comb begin
    bus.stall_o       = stall;
    bus.issue_o       = issue;
    bus.flush_v_o     = (state == ST_FLUSH);
    bus.state_o       = state;
    bus.pending_cnt_o = count;
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  // Stall-cycle counter, holds at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt <= '0;
    end else if (stall && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt_o = perf_cnt;
`else
  // Default build carries no performance counter.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// A queue-based reference model computes the expected outputs every cycle.
// Directed scenarios also pin selected outputs to hand-computed literals.
// Randomized traffic then runs against the same model.
// Optional macro PIPE_HAZARD_CTRL_PERF_EN also checks the stall counter.
module tb_pipe_hazard_ctrl;
  localparam int MAX_LOADS    = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = $clog2(MAX_LOADS + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int     q[$];
  int     flush_left;
  bit     trap_pend;
  bit     in_trap;
  longint perf_model;
  bit     e_issue;
  bit     e_stall;
  bit     e_pop;
  int     e_state;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MAX_LOADS(MAX_LOADS),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic checkValue(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    flush_left = 0;
    trap_pend  = 1'b0;
    in_trap    = 1'b0;
    perf_model = 0;
  endtask

  task automatic modelEval();
    bit run;
    bit haz;
    e_pop = bus.mem_rsp_v_i && (q.size() > 0);
    haz = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      if (!(j == 0 && e_pop)) begin
        if (bus.dec_rs1_v_i && bus.dec_rs1_adr_i != 0 && int'(bus.dec_rs1_adr_i) == q[j]) haz = 1'b1;
        if (bus.dec_rs2_v_i && bus.dec_rs2_adr_i != 0 && int'(bus.dec_rs2_adr_i) == q[j]) haz = 1'b1;
      end
    end
    if (bus.dec_is_load_i && q.size() == MAX_LOADS && !bus.mem_rsp_v_i) haz = 1'b1;
    run     = (flush_left == 0) && !in_trap;
    e_issue = bus.dec_valid_i && run && !haz && !bus.exe_branch_taken_i && !bus.exe_exception_i;
    e_stall = bus.dec_valid_i && run && haz;
    e_state = (flush_left > 0) ? 1 : (in_trap ? 2 : 0);
  endtask

  task automatic modelStep();
    bit run;
    run = (flush_left == 0) && !in_trap;
    if (e_stall && perf_model != 64'hFFFF_FFFF) perf_model++;
    if (e_pop) void'(q.pop_front());
    if (e_issue && bus.dec_is_load_i && bus.dec_rd_adr_i != 0) q.push_back(int'(bus.dec_rd_adr_i));
    if (run && (bus.exe_branch_taken_i || bus.exe_exception_i)) begin
      flush_left = FLUSH_CYCLES;
      trap_pend  = bus.exe_exception_i;
    end else if (flush_left > 0) begin
      flush_left--;
      if (flush_left == 0 && trap_pend) begin
        in_trap   = 1'b1;
        trap_pend = 1'b0;
      end
    end else if (in_trap && bus.trap_done_i) begin
      in_trap = 1'b0;
    end
  endtask

  task automatic checkOutput();
    modelEval();
    checkValue("issue", bus.issue_o, e_issue);
    checkValue("stall", bus.stall_o, e_stall);
    checkValue("flush_v", bus.flush_v_o, (e_state == 1));
    checkValue("state", bus.state_o, e_state);
    checkValue("pending", bus.pending_cnt_o, q.size());
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checkValue("perf", bus.perf_stall_cnt_o, perf_model);
`endif
  endtask

  task automatic driveInputs(input bit v, input bit r1v, input int r1, input bit r2v, input int r2,
                             input bit ld, input int rd, input bit rsp, input bit br,
                             input bit exc, input bit td);
    bus.dec_valid_i        = v;
    bus.dec_rs1_v_i        = r1v;
    bus.dec_rs1_adr_i      = 5'(r1);
    bus.dec_rs2_v_i        = r2v;
    bus.dec_rs2_adr_i      = 5'(r2);
    bus.dec_is_load_i      = ld;
    bus.dec_rd_adr_i       = 5'(rd);
    bus.mem_rsp_v_i        = rsp;
    bus.exe_branch_taken_i = br;
    bus.exe_exception_i    = exc;
    bus.trap_done_i        = td;
  endtask

  // One cycle: drive at negedge, compare just after, advance the model for the coming posedge
  task automatic applyStimulus(input bit v, input bit r1v, input int r1, input bit r2v, input int r2,
                               input bit ld, input int rd, input bit rsp, input bit br,
                               input bit exc, input bit td);
    @(negedge clk);
    driveInputs(v, r1v, r1, r2v, r2, ld, rd, rsp, br, exc, td);
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic applyIdle(input bit rsp);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, rsp, 0, 0, 0);
  endtask

  task automatic doReset();
    driveInputs(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkValue("rst_issue", bus.issue_o, 0);
    checkValue("rst_stall", bus.stall_o, 0);
    checkValue("rst_flush", bus.flush_v_o, 0);
    checkValue("rst_state", bus.state_o, 0);
    checkValue("rst_pending", bus.pending_cnt_o, 0);
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    doReset();

    // Load-use: load x5, then a dependent instruction stalls until the response
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    checkValue("lu_load_issue", bus.issue_o, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      checkValue("lu_stall", bus.stall_o, 1);
      checkValue("lu_no_issue", bus.issue_o, 0);
      checkValue("lu_pending", bus.pending_cnt_o, 1);
    end
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    checkValue("lu_rsp_stall", bus.stall_o, 0);
    checkValue("lu_rsp_issue", bus.issue_o, 1);
    applyIdle(0);
    checkValue("lu_drained", bus.pending_cnt_o, 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checkValue("perf_five", bus.perf_stall_cnt_o, 5);
`endif

    // x0 destination is never tracked and x0 sources never hazard
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkValue("x0_stall", bus.stall_o, 0);
    checkValue("x0_issue", bus.issue_o, 1);
    checkValue("x0_pending", bus.pending_cnt_o, 0);

    // Full queue: third load stalls, then issues alongside a response
    applyStimulus(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
    checkValue("full_stall", bus.stall_o, 1);
    checkValue("full_pending", bus.pending_cnt_o, 2);
    applyStimulus(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    checkValue("full_rsp_issue", bus.issue_o, 1);
    applyIdle(0);
    checkValue("full_kept", bus.pending_cnt_o, 2);
    applyIdle(1);
    applyIdle(1);
    applyIdle(0);
    checkValue("full_drained", bus.pending_cnt_o, 0);

    // Branch: two flush cycles, load still retires during the flush
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkValue("br_issue", bus.issue_o, 0);
    applyIdle(0);
    checkValue("br_flush1", bus.flush_v_o, 1);
    checkValue("br_state1", bus.state_o, 1);
    applyIdle(1);
    checkValue("br_flush2", bus.flush_v_o, 1);
    checkValue("br_pend_in_flush", bus.pending_cnt_o, 1);
    applyIdle(0);
    checkValue("br_flush_end", bus.flush_v_o, 0);
    checkValue("br_state_run", bus.state_o, 0);
    checkValue("br_pop_done", bus.pending_cnt_o, 0);

    // Exception and branch together: flush, then TRAP until trap_done
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkValue("exc_issue", bus.issue_o, 0);
    applyIdle(0);
    checkValue("exc_flush1", bus.state_o, 1);
    applyIdle(0);
    checkValue("exc_flush2", bus.state_o, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkValue("trap_state", bus.state_o, 2);
      checkValue("trap_issue", bus.issue_o, 0);
      checkValue("trap_flush", bus.flush_v_o, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkValue("trap_done_state", bus.state_o, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("trap_resume_state", bus.state_o, 0);
    checkValue("trap_resume_issue", bus.issue_o, 1);

    // Asynchronous reset in the middle of a flush with one load pending
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyIdle(0);
    checkValue("mid_state", bus.state_o, 1);
    bus.dec_valid_i = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checkValue("async_state", bus.state_o, 0);
    checkValue("async_flush", bus.flush_v_o, 0);
    checkValue("async_pending", bus.pending_cnt_o, 0);
    checkValue("async_issue", bus.issue_o, 0);
    checkValue("async_stall", bus.stall_o, 0);
    modelReset();
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyIdle(0);
    checkValue("post_rst_state", bus.state_o, 0);
    checkValue("post_rst_pending", bus.pending_cnt_o, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the decode stage.
- Tracks outstanding load destinations in an in-order scoreboard FIFO.
- Stalls ifetch/dec on load-use hazards or a full load queue, and gates issue from decode to execute.
- Sequences the flush and trap drain after a taken branch or exception from EXE, and drives the decode flush_v.

Parameters:
- MAX_LOADS, 2: outstanding-load FIFO depth, 1..4.
- FLUSH_CYCLES, 2: cycles flush_v_o stays high per flush, ≥1.
- CNT_W, $clog2(MAX_LOADS+1): pending counter width (derived).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- dec_valid_i  in  1  decode holds a valid instruction
- dec_rs1_v_i  in  1  rs1 read from RF
- dec_rs1_adr_i  in  5  rs1 address
- dec_rs2_v_i  in  1  rs2 read from RF
- dec_rs2_adr_i  in  5  rs2 address
- dec_is_load_i  in  1  decoded instruction is a load
- dec_rd_adr_i  in  5  load destination register
- mem_rsp_v_i  in  1  oldest outstanding load writes back this cycle
- exe_branch_taken_i  in  1  EXE redirect request
- exe_exception_i  in  1  EXE exception (illegal_inst etc.)
- trap_done_i  in  1  CSR/trap unit finished the mtvec redirect
- stall_o  out  1  freeze ifetch and decode flops
- issue_o  out  1  decode instruction enters EXE this cycle
- flush_v_o  out  1  flush to decode/ifetch
- state_o  out  2  0=RUN 1=FLUSH 2=TRAP
- pending_cnt_o  out  CNT_W  outstanding loads

Behaviour:
- Reset (async, reset_n low):
  - state=RUN, FIFO empty, pending_cnt_o=0.
  - flush_v_o=0, stall_o=0, issue_o=0, flush counter=0.
- Scoreboard:
  - Circular FIFO of MAX_LOADS rd addresses with rd/wr pointers plus a count.
  - Push on issue_o & dec_is_load_i & (dec_rd_adr_i!=0).
  - Pop on mem_rsp_v_i; mem_rsp_v_i while empty is ignored and the count stays 0.
  - Pointers wrap modulo MAX_LOADS.
- Hazard (combinational):
  - Set when a valid rsN (v=1, adr!=0) equals any valid FIFO entry.
  - An entry popped this same cycle does not count: the RF fast-forward covers it.
  - Also set when dec_is_load_i & full & ~mem_rsp_v_i. Simultaneous push and pop when full is allowed and the count is unchanged.
  - x0 never hazards.
- issue_o = dec_valid_i & state==RUN & ~hazard & ~exe_branch_taken_i & ~exe_exception_i.
- stall_o = dec_valid_i & state==RUN & hazard. Stall is not asserted in FLUSH or TRAP.
- FSM:
  - RUN: exe_exception_i → TRAP-pending flush. Else exe_branch_taken_i → FLUSH. Exception has priority when both are asserted.
  - On either request: the flush counter loads FLUSH_CYCLES and the FSM enters FLUSH next cycle. A trap flag records whether the request was an exception.
  - flush_v_o = state==FLUSH, registered. First high cycle is the cycle after the request; it stays high exactly FLUSH_CYCLES cycles.
  - FLUSH: counter decrements each cycle. At 1, go to TRAP if the trap flag is set, else RUN.
  - TRAP: flush_v_o=0, issue_o=0; wait for trap_done_i, then RUN next cycle.
  - Requests arriving in FLUSH or TRAP are ignored.
- Loads keep draining in every state. Flush never clears the FIFO, because issued loads are architecturally committed.
- The async reset takes effect mid-flush or mid-trap and immediately returns everything to reset values.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- When defined: adds output perf_stall_cnt_o [31:0], counting cycles with stall_o=1. It saturates at 0xFFFFFFFF and resets to 0.
- When undefined: the port and counter are absent, with no other behavioural change.

Test Plan:
- Load-use: issue load rd=5; next cycle dec rs1=5 valid, no mem_rsp → stall_o=1 and issue_o=0 until mem_rsp_v_i. In the mem_rsp cycle stall_o=0 and issue_o=1; pending_cnt 1→0.
- x0 and full: rs1=0 with load rd=0 outstanding → no stall. With MAX_LOADS=2 and 2 pending, a third load stalls; if mem_rsp_v_i arrives the same cycle → issue_o=1 and pending_cnt stays 2.
- Branch: exe_branch_taken_i pulse in RUN → issue_o=0 that cycle, then flush_v_o=1 for exactly 2 cycles, state 1 then 0; pending loads still pop on mem_rsp.
- Exception plus branch in the same cycle → FLUSH for 2 cycles, then TRAP held until trap_done_i; RUN the following cycle and issue resumes.
- Reset asserted during FLUSH with 1 pending load → all outputs 0 asynchronously; after release, state=RUN and pending_cnt_o=0.
- PERF_EN: 5 stall cycles → perf_stall_cnt_o=5. Preload near max → the counter saturates at 0xFFFFFFFF.
